sa_pe_os: RTL and testbench
===========================

# sa_pe_os

Parametrised output-stationary processing element for the systolic array, successor to the 4x4 fixed-width PE. Each PE multiplies a horizontally streamed operand A by a vertically streamed operand B and accumulates locally. Operands carry valid bits, so bubbles do not corrupt the sum. Results leave through a column drain chain with valid qualification, a length-counted drain phase, a signed/unsigned mode and sticky overflow saturation.

## Interface

- DATA_WIDTH, 16: operand width.
- ACC_WIDTH, 40: accumulator and result width; must be ≥ 2*DATA_WIDTH.
- SIGNED, 1: 1 = two's-complement operands and accumulator; 0 = unsigned.
- DRAIN_LEN, 4: number of drain-shift cycles after a load. Equals the number of PEs above this one in the column, plus 1.
- Reset is rst, synchronous, active-high; clock is clk.

Ports:

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; clears accumulator and begins a computation.
- a_in  in  DATA_WIDTH  operand from west neighbour.
- a_vld_in  in  1  a_in valid.
- b_in  in  DATA_WIDTH  operand from north neighbour.
- b_vld_in  in  1  b_in valid.
- result_ld  in  1  pulse; ends computation and loads accumulator into drain register.
- drain_in  in  ACC_WIDTH  result from the PE above.
- drain_vld_in  in  1  drain_in valid.
- a_out  out  DATA_WIDTH  registered a_in to east.
- a_vld_out  out  1  registered a_vld_in.
- b_out  out  DATA_WIDTH  registered b_in to south.
- b_vld_out  out  1  registered b_vld_in.
- drain_out  out  ACC_WIDTH  drain register.
- drain_vld_out  out  1  drain register valid.
- ovf  out  1  sticky; an accumulation saturated since the last start.
- busy  out  1  high in CALC, LOAD and DRAIN.

## Operation

- The FSM has four states: IDLE (0), CALC (1), LOAD (2), DRAIN (3). Reset enters IDLE.
- **IDLE**
  - start moves the FSM to CALC, clears acc to 0 and clears ovf.
  - result_ld is ignored.
- **CALC**
  - When a_vld_in & b_vld_in, acc <= sat(acc + a_in*b_in). Otherwise acc holds.
  - The product is computed at full 2*DATA_WIDTH width, signed or unsigned per SIGNED, then sign- or zero-extended to ACC_WIDTH+1 before the add.
  - sat(): if the sum exceeds the ACC_WIDTH range (signed: [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; unsigned: [0, 2^ACC_WIDTH-1]), clamp to the bound and set ovf.
  - result_ld moves the FSM to LOAD. A valid MAC in the same cycle is included in the loaded value.
  - start in CALC re-clears acc and ovf and stays in CALC; the MAC in that cycle is discarded.
- **LOAD** (one cycle)
  - drain_out <= acc (the final value, including any same-cycle MAC); drain_vld_out <= 1.
  - cnt <= DRAIN_LEN-1; go to DRAIN.
- **DRAIN**
  - Each cycle, drain_out <= drain_in and drain_vld_out <= drain_vld_in; cnt decrements.
  - When cnt == 0 in DRAIN, go to IDLE; that cycle still shifts.
  - If DRAIN_LEN == 1, DRAIN lasts exactly one cycle.
- **Drain register outside LOAD/DRAIN**
  - In IDLE and CALC, drain_out holds and drain_vld_out <= 0.
- **Operand forwarding**
  - a_out, b_out and their valids are registered copies of the inputs every cycle, in every state including IDLE and DRAIN.
  - Forwarding is never stalled.
- **Simultaneous events**
  - rst overrides everything.
  - start in LOAD or DRAIN is ignored.
  - result_ld outside CALC is ignored.

## Timing

- Reset values: FSM = IDLE, acc = 0, a_out = b_out = 0, a_vld_out = b_vld_out = 0, drain_out = 0, drain_vld_out = 0, ovf = 0, busy = 0, cnt = 0.
- Reset mid-operation aborts immediately; the reset values hold on the next edge.
- Operand forwarding latency: 1 cycle.
- MAC: operands sampled on edge N are reflected in acc after edge N; acc is internal.
- result_ld sampled on edge N:
  - edge N+1 (LOAD): drain_out = acc, drain_vld_out = 1.
  - edges N+2 .. N+1+DRAIN_LEN: shift cycles.
  - busy falls after edge N+1+DRAIN_LEN.
- busy is combinational from the state register. ovf is registered.

## Test plan

- **Basic MAC:** SIGNED=1, DW=16, AW=40; start, then 4 valid pairs (3,5),(−2,7),(10,10),(−1,−1), then result_ld. Required: drain_out = 102 with drain_vld_out = 1 one cycle after result_ld; ovf = 0.
- **Bubbles and same-cycle load:** pairs (4,4) and (9,1) with invalid cycles in between, carrying garbage data (0x7FFF, 0x7FFF). Second pair asserted with result_ld. Required: drain_out = 25; invalid cycles contribute nothing.
- **Saturation:** SIGNED=1, AW=32, DW=16; repeated (0x7FFF, 0x7FFF) × 3. Required: drain_out = 0x7FFFFFFF, ovf = 1. A subsequent start clears ovf.
- **Unsigned mode:** SIGNED=0; (0xFFFF, 0xFFFF) once. Required: drain_out = 0xFFFE0001.
- **Drain chain:** DRAIN_LEN=4; drain_in = 0xA1, 0xA2, 0xA3, 0xA4 with valid during the DRAIN cycles. Required: drain_out = 0xA1..0xA4 on successive cycles. busy falls after the 4th shift; drain_vld_out = 0 thereafter.
- **Reset mid-DRAIN:** assert rst during the 2nd DRAIN cycle. Required: next cycle FSM = IDLE, all outputs 0; the following start/MAC sequence is correct.

Source files
------------

// File: rtl/sa_pe_os.sv
// sa_pe_os: output-stationary systolic PE with valid-qualified MAC, saturation and a length-counted drain chain.
module sa_pe_os #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int SIGNED = 1,
  parameter int DRAIN_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_vld_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_vld_in,
  input  logic                  result_ld,
  input  logic [ACC_WIDTH-1:0]  drain_in,
  input  logic                  drain_vld_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_vld_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_vld_out,
  output logic [ACC_WIDTH-1:0]  drain_out,
  output logic                  drain_vld_out,
  output logic                  ovf,
  output logic                  busy
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int CW = DRAIN_LEN > 1 ? $clog2(DRAIN_LEN) : 1;
  localparam logic SX = SIGNED != 0;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, LOAD = 2'd2, DRAIN = 2'd3} state_t;
  state_t state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [2*DW-1:0] a_x, b_x, prod;
  logic [AW:0] sum;
  logic [AW-1:0] sat;
  logic mac, ovf_now;
  // Extending operands to 2*DW first makes the truncated product exact for both signednesses.
  always_comb begin
    a_x = {{DW{SX & a_in[DW-1]}}, a_in};
    b_x = {{DW{SX & b_in[DW-1]}}, b_in};
    prod = a_x * b_x;
    sum = {SX & acc[AW-1], acc} + {{(AW+1-2*DW){SX & prod[2*DW-1]}}, prod};
    ovf_now = SX ? sum[AW] ^ sum[AW-1] : sum[AW];
    sat = ovf_now ? (SX ? {sum[AW], {(AW-1){~sum[AW]}}} : {AW{1'b1}}) : sum[AW-1:0];
    mac = a_vld_in & b_vld_in;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      a_out <= '0;
      a_vld_out <= 1'b0;
      b_out <= '0;
      b_vld_out <= 1'b0;
      drain_out <= '0;
      drain_vld_out <= 1'b0;
      ovf <= 1'b0;
    end else begin
      a_out <= a_in;
      a_vld_out <= a_vld_in;
      b_out <= b_in;
      b_vld_out <= b_vld_in;
      if (state == IDLE || state == CALC) begin
        drain_vld_out <= 1'b0;
        if (start) begin
          state <= CALC;
          acc <= '0;
          ovf <= 1'b0;
        end else if (state == CALC) begin
          if (mac) begin
            acc <= sat;
            ovf <= ovf | ovf_now;
          end
          if (result_ld) state <= LOAD;
        end
      end else if (state == LOAD) begin
        drain_out <= acc;
        drain_vld_out <= 1'b1;
        cnt <= CW'(DRAIN_LEN - 1);
        state <= DRAIN;
      end else begin
        drain_out <= drain_in;
        drain_vld_out <= drain_vld_in;
        cnt <= cnt - 1'b1;
        if (cnt == '0) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sa_pe_os.sv
// tb_sa_pe_os: directed checks of sa_pe_os in signed 40-bit, signed 32-bit and unsigned 32-bit builds sharing one stimulus.
module tb_sa_pe_os;
  logic clk = 0, rst, start, a_vld_in, b_vld_in, result_ld, drain_vld_in;
  logic [15:0] a_in, b_in;
  logic [39:0] drain_in;
  logic [15:0] ao40, bo40, ao32, bo32, aou, bou;
  logic av40, bv40, av32, bv32, avu, bvu;
  logic [39:0] do40;
  logic [31:0] do32, dou;
  logic dv40, dv32, dvu, ovf40, ovf32, ovfu, busy40, busy32, busyu;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sa_pe_os #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SIGNED(1), .DRAIN_LEN(4)) d40 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .result_ld(result_ld), .drain_in(drain_in), .drain_vld_in(drain_vld_in), .a_out(ao40), .a_vld_out(av40),
    .b_out(bo40), .b_vld_out(bv40), .drain_out(do40), .drain_vld_out(dv40), .ovf(ovf40), .busy(busy40));
  sa_pe_os #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(1), .DRAIN_LEN(4)) d32 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .result_ld(result_ld), .drain_in(drain_in[31:0]), .drain_vld_in(drain_vld_in), .a_out(ao32), .a_vld_out(av32),
    .b_out(bo32), .b_vld_out(bv32), .drain_out(do32), .drain_vld_out(dv32), .ovf(ovf32), .busy(busy32));
  sa_pe_os #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(0), .DRAIN_LEN(4)) du (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .result_ld(result_ld), .drain_in(drain_in[31:0]), .drain_vld_in(drain_vld_in), .a_out(aou), .a_vld_out(avu),
    .b_out(bou), .b_vld_out(bvu), .drain_out(dou), .drain_vld_out(dvu), .ovf(ovfu), .busy(busyu));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic st, input logic av, input logic [15:0] a, input logic bv, input logic [15:0] b, input logic ld);
    start = st;
    a_vld_in = av;
    a_in = a;
    b_vld_in = bv;
    b_in = b;
    result_ld = ld;
  endtask
  task automatic mac(input logic [15:0] a, input logic [15:0] b, input logic ld);
    drive(0, 1, a, 1, b, ld);
    tick();
  endtask
  task automatic idle_drain();
    drive(0, 0, 0, 0, 0, 0);
    drain_vld_in = 0;
    repeat (4) tick();
  endtask
  initial begin
    rst = 1;
    drain_in = 0;
    drain_vld_in = 0;
    drive(0, 1, 16'h1234, 1, 16'h5678, 0);
    tick();
    tick();
    chk("rst_drain", do40, 0);
    chk("rst_dvld", dv40, 0);
    chk("rst_busy", busy40, 0);
    chk("rst_ovf", ovf40, 0);
    chk("rst_aout", ao40, 0);
    chk("rst_bvld", bv40, 0);
    rst = 0;
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("idle_ld_ignored", busy40, 0);
    // basic MAC: 15 - 14 + 100 + 1 = 102
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("start_busy", busy40, 1);
    mac(16'd3, 16'd5, 0);
    chk("fwd_a", ao40, 3);
    chk("fwd_b", bo40, 5);
    chk("fwd_av", av40, 1);
    mac(16'hFFFE, 16'd7, 0);
    mac(16'd10, 16'd10, 0);
    mac(16'hFFFF, 16'hFFFF, 0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("load_dvld_pre", dv40, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("basic_drain", do40, 102);
    chk("basic_dvld", dv40, 1);
    chk("basic_ovf", ovf40, 0);
    for (int i = 1; i <= 4; i++) begin
      drain_in = 40'hA0 + 40'(i);
      drain_vld_in = 1;
      drive(i == 2, 0, 0, 0, 0, 0);
      tick();
      chk("chain_val", do40, 40'hA0 + 64'(i));
      chk("chain_vld", dv40, 1);
      chk("chain_busy", busy40, i < 4);
    end
    start = 0;
    tick();
    chk("post_drain_vld", dv40, 0);
    chk("post_drain_hold", do40, 40'hA4);
    drain_vld_in = 0;
    // bubbles with garbage data, last pair coincides with result_ld
    drive(1, 0, 0, 0, 0, 0);
    tick();
    mac(16'd4, 16'd4, 0);
    drive(0, 1, 16'h7FFF, 0, 16'h7FFF, 0);
    tick();
    drive(0, 0, 16'h7FFF, 1, 16'h7FFF, 0);
    tick();
    drive(0, 0, 16'h7FFF, 0, 16'h7FFF, 0);
    tick();
    mac(16'd9, 16'd1, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("bubble_drain", do40, 25);
    chk("bubble_dvld", dv40, 1);
    idle_drain();
    chk("bubble_idle", busy40, 0);
    // saturation in the 32-bit signed build: third MAC exceeds 0x7FFFFFFF
    drive(1, 0, 0, 0, 0, 0);
    tick();
    mac(16'h7FFF, 16'h7FFF, 0);
    mac(16'h7FFF, 16'h7FFF, 0);
    chk("sat_no_ovf_yet", ovf32, 0);
    mac(16'h7FFF, 16'h7FFF, 0);
    chk("sat_ovf32", ovf32, 1);
    chk("sat_ovf40", ovf40, 0);
    chk("sat_ovfu", ovfu, 0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("sat_drain32", do32, 32'h7FFFFFFF);
    chk("sat_drain40", do40, 40'hBFFD0003);
    chk("sat_drainu", dou, 32'hBFFD0003);
    idle_drain();
    chk("sat_ovf_sticky", ovf32, 1);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("sat_ovf_clear", ovf32, 0);
    // unsigned vs signed interpretation of 0xFFFF * 0xFFFF
    mac(16'hFFFF, 16'hFFFF, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("unsigned_drain", dou, 32'hFFFE0001);
    chk("signed_drain", do32, 1);
    idle_drain();
    // negative saturation: -32768*32767 accumulated until it passes -2^31
    drive(1, 0, 0, 0, 0, 0);
    tick();
    repeat (3) mac(16'h8000, 16'h7FFF, 0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("negsat_drain", do32, 32'h80000000);
    chk("negsat_ovf", ovf32, 1);
    idle_drain();
    // reset during the second DRAIN cycle
    drive(1, 0, 0, 0, 0, 0);
    tick();
    mac(16'd2, 16'd3, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("pre_rst_drain", do40, 6);
    drain_in = 40'hB1;
    drain_vld_in = 1;
    tick();
    chk("pre_rst_shift", do40, 40'hB1);
    rst = 1;
    drive(0, 1, 16'd5, 1, 16'd6, 0);
    tick();
    chk("mid_rst_drain", do40, 0);
    chk("mid_rst_dvld", dv40, 0);
    chk("mid_rst_busy", busy40, 0);
    chk("mid_rst_aout", ao40, 0);
    chk("mid_rst_ovf", ovf32, 0);
    rst = 0;
    drain_vld_in = 0;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 16'd100, 1, 16'd100, 0);
    tick();
    mac(16'd6, 16'd7, 0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("post_rst_drain", do40, 42);
    chk("post_rst_dvld", dv40, 1);
    idle_drain();
    chk("final_busy", busy40, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
